// File: rtl/shift_arbiter_if.sv
// Request/result bundle for the two-requester shift arbiter.
// The master drives requests and consumes results; the slave is the arbiter.
interface shift_arbiter_if #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int OPS         = 2
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_data;
    logic [SHIFT_WIDTH-1:0] req0_shift;
    logic [OPS-1:0]         req0_op;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_data;
    logic [SHIFT_WIDTH-1:0] req1_shift;
    logic [OPS-1:0]         req1_op;

    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_data;
    logic                   res_id;

    modport master (
        output req0_valid, req0_data, req0_shift, req0_op,
        output req1_valid, req1_data, req1_shift, req1_op,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_shift, req0_op,
        input  req1_valid, req1_data, req1_shift, req1_op,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two requesters share one combinational shifter under round-robin arbitration;
// results queue in a 2-entry in-order FIFO tagged with the issuing requester.
module shifter #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int OPS         = 2
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [OPS-1:0]         op,
    output logic [WIDTH-1:0]       result
);
    localparam logic [OPS-1:0] LEFT_SHIFTA  = OPS'(0);
    localparam logic [OPS-1:0] LEFT_SHIFTL  = OPS'(1);
    localparam logic [OPS-1:0] RIGHT_SHIFTA = OPS'(2);
    localparam logic [OPS-1:0] RIGHT_SHIFTL = OPS'(3);

    always_comb begin
        result = data;
        case (op)
            LEFT_SHIFTA,
            LEFT_SHIFTL:  result = data << shift;
            RIGHT_SHIFTA: result = $unsigned($signed(data) >>> shift);
            RIGHT_SHIFTL: result = data >> shift;
            // unknown codes pass the operand through unchanged
            default:      result = data;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int OPS         = 2
) (
    input logic            clk,
    input logic            rst_n,
    shift_arbiter_if.slave bus
);
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  prio_q, prio_d;
    logic [1:0][WIDTH-1:0] mem_data_q, mem_data_d;
    logic [1:0]            mem_id_q, mem_id_d;

    logic                   grant, can_accept, push, pop, not_empty;
    logic                   ready0, ready1;
    logic [WIDTH-1:0]       sh_data, sh_result;
    logic [SHIFT_WIDTH-1:0] sh_shift;
    logic [OPS-1:0]         sh_op;

    shifter #(.WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .OPS(OPS)) u_shifter (
        .data   (sh_data),
        .shift  (sh_shift),
        .op     (sh_op),
        .result (sh_result)
    );

    always_comb begin
        not_empty  = (count_q != 2'd0);
        pop        = not_empty & bus.res_ready;
        can_accept = (count_q < 2'd2) | pop;
        case ({bus.req1_valid, bus.req0_valid})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = prio_q;
        endcase
        // ready is held low while reset is asserted, not just after the next edge
        ready0   = rst_n & can_accept & ~grant;
        ready1   = rst_n & can_accept & grant;
        push     = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);
        sh_data  = grant ? bus.req1_data  : bus.req0_data;
        sh_shift = grant ? bus.req1_shift : bus.req0_shift;
        sh_op    = grant ? bus.req1_op    : bus.req0_op;
    end

    always_comb begin
        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        prio_d     = prio_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_data_d[wr_ptr_q] = sh_result;
            mem_id_d[wr_ptr_q]   = grant;
            wr_ptr_d             = ~wr_ptr_q;
            prio_d               = ~grant;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            prio_q     <= 1'b0;
            mem_data_q <= '0;
            mem_id_q   <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            prio_q     <= prio_d;
            mem_data_q <= mem_data_d;
            mem_id_q   <= mem_id_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = not_empty;
    assign bus.res_data   = mem_data_q[rd_ptr_q];
    assign bus.res_id     = mem_id_q[rd_ptr_q];
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and results.
REQ-002 Parameter SHIFT_WIDTH, default 5, shift-amount width.
REQ-003 Parameter OPS, default 2, op-code width; codes LEFT_SHIFTA, LEFT_SHIFTL, RIGHT_SHIFTA, RIGHT_SHIFTL as defined for shifter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  out  1  requester N operation accepted this cycle when high with reqN_valid.
REQ-008 reqN_data  in  WIDTH  operand of requester N.
REQ-009 reqN_shift  in  SHIFT_WIDTH  shift amount of requester N.
REQ-010 reqN_op  in  OPS  shift op of requester N.
REQ-011 res_valid  out  1  res_data/res_id hold a valid result.
REQ-012 res_ready  in  1  consumer accepts result this cycle.
REQ-013 res_data  out  WIDTH  shifted result.
REQ-014 res_id  out  1  index of requester that issued the result.

Function
REQ-015 Block SHALL contain exactly one shifter instance, shared by both requesters; granted request's data/shift/op drive it combinationally.
REQ-016 Results SHALL be written into a 2-entry in-order result FIFO (entry = WIDTH-bit result + 1-bit id); res_* SHALL present the FIFO head.
REQ-017 count (0..2) SHALL track FIFO occupancy; push = accept, pop = res_valid & res_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-018 can_accept SHALL be (count < 2) | pop; with count==2 and res_ready low, both reqN_ready SHALL be 0.
REQ-019 Arbitration SHALL be round-robin via 1-bit pointer prio: only one valid -> that one granted; both valid -> requester prio granted.
REQ-020 On every accept, prio SHALL become the non-granted index; no accept -> prio unchanged.
REQ-021 reqN_ready SHALL be high only for the granted requester and only when can_accept; at most one ready per cycle.
REQ-022 reqN_ready SHALL not depend on reqN_valid of the same requester except through grant selection; no combinational path from res_ready to res_valid.
REQ-023 Latency: request accepted at edge k SHALL appear at FIFO head (res_valid=1) after edge k when FIFO was empty; otherwise behind older entries, order preserved.
REQ-024 Throughput: one accept per cycle sustained when res_ready held high.
REQ-025 res_valid SHALL equal (count != 0); res_data/res_id SHALL be stable while res_valid & !res_ready.
REQ-026 Write/read pointers SHALL wrap modulo 2.
REQ-027 Result values SHALL match shifter semantics: arithmetic right fills sign, logical fills zero, shift amount 0 returns data unchanged.
REQ-028 Invalid op code SHALL still be accepted and result passed through as shifter produces it; no error flag.

Reset
REQ-029 rst_n low SHALL immediately clear count, pointers, prio (to 0), res_valid, reqN_ready; res_data and res_id SHALL read 0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents; no result emitted after release until a new accept.
REQ-031 First rising edge after rst_n release SHALL be able to accept a request.

Verification
REQ-032 Single req: req0 data=32'h8000_0000, shift=4, op=RIGHT_SHIFTA, res_ready=1 -> res_valid next cycle, res_data=32'hF800_0000, res_id=0.
REQ-033 Contention: both valid every cycle after reset, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1.
REQ-034 Backpressure: res_ready=0, req1 valid 4 cycles -> exactly 2 accepts, then req1_ready=0; count=2; raise res_ready -> results pop in order, accepts resume same cycle as first pop.
REQ-035 Push+pop: count=1, res_ready=1, req0 valid -> count stays 1, new result follows head.
REQ-036 Reset mid-stream: FIFO holding 2 results, pull rst_n low -> res_valid=0 immediately; after release no stale result appears.
REQ-037 Random: 32 random operands, shift=5, all four ops, random valid/ready -> every result equals reference shift of its request, per-requester order preserved.
